// File: rtl/seg_scan_module_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
//   scan_state_t : per-slot phase (ghosting guard, then digit drive)
//   HEX_GLYPH    : active-high a..g patterns (bit 0 = a, bit 6 = g) for hex 0..F
package seg_scan_module_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg_scan_module_hex.sv
// seg_hex_decode: combinational nibble to 7-segment glyph lookup.
//   nibble : 4-bit hex value
//   glyph  : active-high segments a..g on bits 0..6
module seg_hex_decode
    import seg_scan_module_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = HEX_GLYPH[nibble];
    end

endmodule

// File: rtl/seg_scan_module.sv
// seg_scan_module: four-digit multiplexed hex display scanner.
// Each digit owns a slot of DIV_FACTOR clocks; the first BLANK_CYCLES of a
// slot drive everything off to suppress ghosting. New display contents are
// staged in a pending register and only take effect at the digit 3->0 wrap,
// so a frame never shows a mix of old and new values.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   data       : four hex nibbles, data[3:0] = digit 0
//   dp_en      : decimal point enable per digit
//   blank_en   : per-digit blank (slot kept, segments off)
//   load       : one-cycle strobe capturing data/dp_en/blank_en
//   seg        : segments a..g on bits 0..6, dp on bit 7 (registered)
//   dig        : one-hot digit select (registered)
//   frame_done : one-cycle pulse when the index wraps 3->0 (registered)
module seg_scan_module
    import seg_scan_module_pkg::*;
#(
    parameter int unsigned DIV_FACTOR   = 48_000,
    parameter int unsigned BLANK_CYCLES = 480,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [3:0]  dp_en,
    input  logic [3:0]  blank_en,
    input  logic        load,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_done
);

    localparam logic [31:0] CNT_LAST   = 32'(DIV_FACTOR - 1);
    localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYCLES) - 32'd1;
    localparam logic [7:0]  SEG_OFF    = {8{ACTIVE_LOW}};
    localparam logic [3:0]  DIG_OFF    = {4{ACTIVE_LOW}};

    logic [31:0] cnt;
    logic [1:0]  idx;
    scan_state_t state, state_nxt;
    logic        tick;
    logic        wrap;

    logic [15:0] disp_data, pend_data;
    logic [3:0]  disp_dp, disp_bl, pend_dp, pend_bl;
    logic        pend_flag;

    logic [3:0]  nibble;
    logic [6:0]  glyph;
    logic [7:0]  seg_ah;
    logic [3:0]  dig_ah;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == 2'd3);

    // Prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_BLANK;
        else     state <= state_nxt;
    end

    // BLANK covers slot counts 0..BLANK_CYCLES-1; a zero guard goes straight to DRIVE.
    always_comb begin
        state_nxt = state;
        if (tick) begin
            state_nxt = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        end else if (state == ST_BLANK) begin
            if ((BLANK_CYCLES == 0) || (cnt == BLANK_LAST))
                state_nxt = ST_DRIVE;
        end
    end

    // Pending/display registers; a load on the wrap edge bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            disp_dp   <= '0;
            disp_bl   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_bl   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp_en;
                pend_bl   <= blank_en;
            end
            if (wrap) begin
                pend_flag <= 1'b0;
                if (load) begin
                    disp_data <= data;
                    disp_dp   <= dp_en;
                    disp_bl   <= blank_en;
                end else if (pend_flag) begin
                    disp_data <= pend_data;
                    disp_dp   <= pend_dp;
                    disp_bl   <= pend_bl;
                end
            end else if (load) begin
                pend_flag <= 1'b1;
            end
        end
    end

    assign nibble = disp_data[{idx, 2'b00} +: 4];

    seg_hex_decode u_hex (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        seg_ah = '0;
        dig_ah = '0;
        if (state == ST_DRIVE) begin
            dig_ah = 4'b0001 << idx;
            if (!disp_bl[idx])
                seg_ah = {disp_dp[idx], glyph};
        end
    end

    // Output registers; polarity is applied only here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dig        <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_ah ^ SEG_OFF;
            dig        <= dig_ah ^ DIG_OFF;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_module.sv
// Self-checking bench for seg_scan_module (DIV_FACTOR=8, BLANK_CYCLES=2,
// ACTIVE_LOW=1). The reference model tracks time since reset release as a
// frame position (0..31) and keeps displayed/pending contents as plain values.
module tb_seg_scan_module;

    localparam int DIV = 8;
    localparam int BC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic [3:0]  dp_en = '0;
    logic [3:0]  blank_en = '0;
    logic        load = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    seg_scan_module #(
        .DIV_FACTOR   (DIV),
        .BLANK_CYCLES (BC),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_en      (dp_en),
        .blank_en   (blank_en),
        .load       (load),
        .seg        (seg),
        .dig        (dig),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Standard hex glyphs, a..g on bits 0..6, active-high
    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state
    int          k;                 // edges since reset release
    logic [15:0] m_data, p_data;
    logic [3:0]  m_dp, m_bl, p_dp, p_bl;
    bit          p_flag;
    int          loads_seen_1111;

    task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, act, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_data = '0; m_dp = '0; m_bl = '0;
        p_data = '0; p_dp = '0; p_bl = '0;
        p_flag = 0;
    endtask

    // One clock with the given inputs, then compare against the model.
    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        int pos, slot, c;
        logic [7:0] e_seg;
        logic [3:0] e_dig;
        logic       e_fd;
        logic [3:0] nib;
        load = ld; data = d; dp_en = dp; blank_en = bl;
        pos  = k % (4 * DIV);
        slot = pos / DIV;
        c    = pos % DIV;
        e_seg = 8'hFF;
        e_dig = 4'hF;
        if (c >= BC) begin
            e_dig = ~(4'b0001 << slot);
            nib   = m_data[slot*4 +: 4];
            if (!m_bl[slot]) e_seg = ~{m_dp[slot], glyphs[nib]};
        end
        e_fd = (pos == 4 * DIV - 1);
        if (e_fd) begin
            if (ld) begin
                m_data = d; m_dp = dp; m_bl = bl;
            end else if (p_flag) begin
                m_data = p_data; m_dp = p_dp; m_bl = p_bl;
            end
            p_flag = 0;
        end else if (ld) begin
            p_data = d; p_dp = dp; p_bl = bl; p_flag = 1;
        end
        k++;
        @(posedge clk);
        #1;
        load = 1'b0;
        check8("seg", seg, e_seg);
        check8("dig", {4'h0, dig}, {4'h0, e_dig});
        check8("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
        if (dig == 4'hE && seg == ~{1'b0, glyphs[1]} && m_data == 16'h2222) loads_seen_1111++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic run_to_pos(input int p);
        while ((k % (4 * DIV)) != p) step(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    initial begin
        model_reset();
        loads_seen_1111 = 0;

        // Outputs off while in reset
        repeat (2) @(posedge clk);
        #1;
        check8("rst_seg", seg, 8'hFF);
        check8("rst_dig", {4'h0, dig}, 8'h0F);
        check8("rst_fd", {7'h0, frame_done}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Idle scan showing zeros
        idle(70);

        // Mid-frame load takes effect only at the wrap
        run_to_pos(10);
        step(1'b1, 16'h8A10, 4'b1000, 4'b0000);
        idle(70);

        // Two loads in one frame: last one wins
        run_to_pos(5);
        step(1'b1, 16'h1111, 4'h0, 4'h0);
        idle(6);
        step(1'b1, 16'h2222, 4'h0, 4'h0);
        idle(70);
        check8("no_1111_shown", loads_seen_1111[7:0], 8'd0);

        // Load on the wrap edge commits directly
        run_to_pos(31);
        step(1'b1, 16'hFFFF, 4'h0, 4'h0);
        idle(40);

        // Blank digit 1 only
        run_to_pos(3);
        step(1'b1, 16'h4321, 4'b0101, 4'b0010);
        idle(70);

        // Randomized loads
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) < 4 ? $urandom : 0));
            else
                step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
        end

        // Asynchronous reset during slot 2
        run_to_pos(19);
        rst = 1'b1;
        #1;
        check8("async_seg", seg, 8'hFF);
        check8("async_dig", {4'h0, dig}, 8'h0F);
        check8("async_fd", {7'h0, frame_done}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check8("hold_seg", seg, 8'hFF);
        check8("hold_fd", {7'h0, frame_done}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
